// File: rtl/aes256_round_key_sched_if.sv
// aes256_round_key_sched_if: start/key request and round-key stream between scheduler and cipher datapath.
// KEY_SCHED_REVERSE_EN adds the reverse request bit.
interface aes256_round_key_sched_if;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         done;
`ifdef KEY_SCHED_REVERSE_EN
    logic         reverse;
    modport master (output start, key_in, reverse, rk_ready, input busy, rk_out, rk_idx, rk_valid, done);
    modport slave (input start, key_in, reverse, rk_ready, output busy, rk_out, rk_idx, rk_valid, done);
`else
    modport master (output start, key_in, rk_ready, input busy, rk_out, rk_idx, rk_valid, done);
    modport slave (input start, key_in, rk_ready, output busy, rk_out, rk_idx, rk_valid, done);
`endif
endinterface

// File: rtl/aes256_round_key_sched.sv
// aes256_round_key_sched: sequential AES-256 key schedule streaming round keys 0..14 over valid/ready.
// Define KEY_SCHED_REVERSE_EN to add precomputed reverse-order (decryption) delivery.
module aes256_round_key_sched #(
    parameter int NR  = 14,
    parameter int RKW = 128
) (
    input logic clk,
    input logic rst,
    aes256_round_key_sched_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, EMIT_HI = 3'd1, EMIT_LO = 3'd2, FIN = 3'd3;
`ifdef KEY_SCHED_REVERSE_EN
    localparam logic [2:0] PRECOMP = 3'd4, EMIT_REV = 3'd5;
    logic [RKW-1:0] buf_q [0:NR];
`endif

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] y, r;
        y = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [255:0] expand(input logic [3:0] rc, input logic [255:0] k);
        logic [31:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        w[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {8'h01 << rc, 24'h0};
        for (int i = 1; i < 8; i++) w[i] = w[i] ^ (i == 4 ? sub_word(w[3]) : w[i-1]);
        return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
    endfunction

    logic [2:0]       state_q, state_d;
    logic [2*RKW-1:0] kr_q, kr_d, kr_nxt;
    logic [3:0]       rc_q, rc_d, rc_inc, idx_q, idx_d;
    logic             accept, last;

    assign kr_nxt  = expand(rc_q, kr_q);
    assign rc_inc  = rc_q == 4'd6 ? rc_q : rc_q + 4'd1;
    assign accept  = bus.rk_valid & bus.rk_ready;
    assign last    = idx_q == 4'(NR);
    assign bus.busy   = state_q != IDLE && state_q != FIN;
    assign bus.done   = state_q == FIN;
    assign bus.rk_idx = idx_q;
`ifdef KEY_SCHED_REVERSE_EN
    assign bus.rk_valid = state_q == EMIT_HI || state_q == EMIT_LO || state_q == EMIT_REV;
    assign bus.rk_out   = state_q == EMIT_HI ? kr_q[2*RKW-1:RKW] :
                          state_q == EMIT_LO ? kr_q[RKW-1:0] :
                          state_q == EMIT_REV ? buf_q[idx_q] : '0;
`else
    assign bus.rk_valid = state_q == EMIT_HI || state_q == EMIT_LO;
    assign bus.rk_out   = state_q == EMIT_HI ? kr_q[2*RKW-1:RKW] :
                          state_q == EMIT_LO ? kr_q[RKW-1:0] : '0;
`endif

    always_comb begin
        state_d = state_q;
        kr_d    = kr_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (bus.start) begin
                kr_d    = bus.key_in;
                rc_d    = '0;
                idx_d   = '0;
`ifdef KEY_SCHED_REVERSE_EN
                state_d = bus.reverse ? PRECOMP : EMIT_HI;
`else
                state_d = EMIT_HI;
`endif
            end
            EMIT_HI: if (accept) begin
                state_d = last ? FIN : EMIT_LO;
                idx_d   = last ? idx_q : idx_q + 4'd1;
            end
            // expansion happens as the LO half leaves, so HI of the next pair is ready without a bubble
            EMIT_LO: if (accept) begin
                kr_d    = kr_nxt;
                rc_d    = rc_inc;
                idx_d   = idx_q + 4'd1;
                state_d = EMIT_HI;
            end
`ifdef KEY_SCHED_REVERSE_EN
            PRECOMP: begin
                kr_d    = kr_nxt;
                rc_d    = rc_inc;
                state_d = rc_q == 4'd6 ? EMIT_REV : PRECOMP;
                idx_d   = rc_q == 4'd6 ? 4'(NR) : idx_q;
            end
            EMIT_REV: if (accept) begin
                state_d = idx_q == '0 ? FIN : EMIT_REV;
                idx_d   = idx_q == '0 ? idx_q : idx_q - 4'd1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kr_q    <= '0;
            rc_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            kr_q    <= kr_d;
            rc_q    <= rc_d;
            idx_q   <= idx_d;
        end
    end

`ifdef KEY_SCHED_REVERSE_EN
    always_ff @(posedge clk) begin
        if (state_q == PRECOMP) begin
            buf_q[{rc_q[2:0], 1'b0}] <= kr_q[2*RKW-1:RKW];
            buf_q[{rc_q[2:0], 1'b1}] <= kr_q[RKW-1:0];
            if (rc_q == 4'd6) buf_q[NR] <= kr_nxt[2*RKW-1:RKW];
        end
    end
`endif
endmodule

// File: tb/tb_aes256_round_key_sched.sv
// tb_aes256_round_key_sched: directed + randomized checks of the round-key stream against a
// word-wise FIPS-197 key expansion model.
module tb_aes256_round_key_sched;
    logic clk = 0;
    logic rst = 1;
    int vectors = 0;
    int miscompares = 0;
    int cyc;
    logic [127:0] exp_rk [15];
    logic [127:0] got [15];
    logic [255:0] k2;

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam bit [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    aes256_round_key_sched_if bus();
    aes256_round_key_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Standard 60-word AES-256 expansion; round key r is words 4r..4r+3
    task automatic build(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0};
            end else if (i % 8 == 4) t = subw(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_sched(input logic [255:0] key);
        build(key);
        bus.start = 1;
        bus.key_in = key;
        @(negedge clk);
        bus.start = 0;
    endtask

    // Consume keys number from..upto-1 with random stalls, checking order, values and stall stability
    task automatic stream(input bit rev, input int stall, input int from, input int upto, output int cycles);
        int n;
        int e;
        bit held;
        logic [127:0] ho;
        logic [3:0] hi;
        n = from;
        held = 0;
        cycles = 0;
        while (n < upto && cycles < 500) begin
            bus.rk_ready = ($urandom_range(99) >= stall);
            if (held) begin
                check("hold_valid", 128'(bus.rk_valid), 128'(1));
                check("hold_out", bus.rk_out, ho);
                check("hold_idx", 128'(bus.rk_idx), 128'(hi));
            end
            held = 0;
            if (bus.rk_valid) begin
                e = rev ? 14 - n : n;
                if (bus.rk_ready) begin
                    check("idx", 128'(bus.rk_idx), 128'(e));
                    check("key", bus.rk_out, exp_rk[e]);
                    got[e] = bus.rk_out;
                    n++;
                end else begin
                    held = 1;
                    ho = bus.rk_out;
                    hi = bus.rk_idx;
                end
            end
            @(negedge clk);
            cycles++;
        end
        bus.rk_ready = 0;
        if (n < upto) check("stream_timeout", 128'(n), 128'(upto));
    endtask

    task automatic finish_check();
        check("done", 128'(bus.done), 128'(1));
        check("busy_fin", 128'(bus.busy), 128'(0));
        check("valid_fin", 128'(bus.rk_valid), 128'(0));
        @(negedge clk);
        check("done_pulse", 128'(bus.done), 128'(0));
    endtask

    initial begin
        bus.start = 0;
        bus.key_in = '0;
        bus.rk_ready = 0;
`ifdef KEY_SCHED_REVERSE_EN
        bus.reverse = 0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_valid", 128'(bus.rk_valid), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_idx", 128'(bus.rk_idx), 128'(0));
        check("rst_out", bus.rk_out, 128'(0));
        rst = 0;
        @(negedge clk);

        start_sched(FIPS_KEY);
        check("lat_valid", 128'(bus.rk_valid), 128'(1));
        check("lat_busy", 128'(bus.busy), 128'(1));
        stream(0, 0, 0, 15, cyc);
        check("b2b_cycles", 128'(cyc), 128'(15));
        check("fips0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("fips1", got[1], 128'h101112131415161718191a1b1c1d1e1f);
        check("fips2", got[2], 128'ha573c29fa176c498a97fce93a572c09c);
        check("fips3", got[3], 128'h1651a8cd0244beda1a5da4c10640bade);
        check("fips14", got[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        finish_check();

        start_sched(FIPS_KEY);
        stream(0, 40, 0, 15, cyc);
        finish_check();

        start_sched(rand_key());
        stream(0, 30, 0, 4, cyc);
        bus.start = 1;
        bus.key_in = rand_key();
        @(negedge clk);
        bus.start = 0;
        stream(0, 30, 4, 15, cyc);
        finish_check();

        start_sched(rand_key());
        stream(0, 20, 0, 6, cyc);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_valid", 128'(bus.rk_valid), 128'(0));
        check("mid_rst_busy", 128'(bus.busy), 128'(0));
        check("mid_rst_idx", 128'(bus.rk_idx), 128'(0));
        check("mid_rst_done", 128'(bus.done), 128'(0));
        @(negedge clk);
        check("mid_rst_nodone", 128'(bus.done), 128'(0));
        start_sched(rand_key());
        stream(0, 25, 0, 15, cyc);

        check("b2b_done", 128'(bus.done), 128'(1));
        k2 = rand_key();
        build(k2);
        bus.start = 1;
        bus.key_in = k2;
        @(negedge clk);
        check("fin_start_ignored_busy", 128'(bus.busy), 128'(0));
        check("fin_start_ignored_valid", 128'(bus.rk_valid), 128'(0));
        @(negedge clk);
        bus.start = 0;
        check("b2b_valid", 128'(bus.rk_valid), 128'(1));
        check("b2b_idx", 128'(bus.rk_idx), 128'(0));
        stream(0, 0, 0, 15, cyc);
        finish_check();

        for (int t = 0; t < 4; t++) begin
            start_sched(rand_key());
            stream(0, $urandom_range(60), 0, 15, cyc);
            finish_check();
        end

`ifdef KEY_SCHED_REVERSE_EN
        for (int t = 0; t < 3; t++) begin
            bus.reverse = 1;
            start_sched(t == 0 ? FIPS_KEY : rand_key());
            bus.reverse = 0;
            for (int i = 0; i < 7; i++) begin
                check("rev_pre_valid", 128'(bus.rk_valid), 128'(0));
                check("rev_pre_busy", 128'(bus.busy), 128'(1));
                @(negedge clk);
            end
            check("rev_lat_valid", 128'(bus.rk_valid), 128'(1));
            check("rev_first_idx", 128'(bus.rk_idx), 128'(14));
            stream(1, t == 0 ? 0 : 35, 0, 15, cyc);
            if (t == 0) begin
                check("rev_fips14", got[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
                check("rev_fips0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
            end
            finish_check();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
